// File: rtl/dbg_pkg.sv
// Shared opcodes, FSM encoding and frame layout for the debug command path.
package dbg_pkg;

    localparam int FRAME_W = 9;

    localparam logic [2:0] OP_NOP       = 3'b000;
    localparam logic [2:0] OP_DEBUG_ON  = 3'b001;
    localparam logic [2:0] OP_DEBUG_OFF = 3'b010;
    localparam logic [2:0] OP_SELECT    = 3'b011;
    localparam logic [2:0] OP_READ      = 3'b100;
    localparam logic [2:0] OP_WRITE     = 3'b101;
    localparam logic [2:0] OP_CLR_FLAGS = 3'b110;
    localparam logic [2:0] OP_RSVD      = 3'b111;

    localparam logic [2:0]         RSP_READ  = 3'b100;
    localparam logic [FRAME_W-1:0] NAK_FRAME = 9'b111_000000;

    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t RD_WAIT = 2'd1;
    localparam state_t SEND    = 2'd2;

    typedef struct packed {
        logic [2:0] op;
        logic [5:0] payload;
    } frame_t;

endpackage

// File: rtl/dbg_tx_timer.sv
// Purpose: saturating wait counter that flags when a response has waited LIMIT cycles.
// Latency: expire is combinational on the LIMIT-th enabled cycle after load.
// Backpressure: none; counting pauses while en is low.
module dbg_tx_timer #(
    parameter int LIMIT = 255,
    parameter int CNT_W = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    // The count would reach LIMIT on this enabled cycle.
    assign expire = en && (cnt >= LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/debug_cmd_sequencer.sv
// Purpose: decodes debug command frames, drives debug/register bank, returns responses.
// Latency: READ response tx_valid 2+READ_LAT cycles after frame_valid; others 1 cycle.
// Backpressure: holds tx_frame until tx_ready or TX_TIMEOUT; frames while busy set overrun.
module debug_cmd_sequencer
    import dbg_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 4,
    parameter int READ_LAT   = 1,
    parameter int TX_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_valid,
    input  logic [8:0]         frame,
    input  logic [DATA_W-1:0]  rd_data,
    input  logic               tx_ready,
    output logic               debug,
    output logic [ADDR_W-1:0]  reg_addr,
    output logic               rd_en,
    output logic               wr_en,
    output logic [DATA_W-1:0]  wr_data,
    output logic               tx_valid,
    output logic [8:0]         tx_frame,
    output logic               busy,
    output logic               overrun,
    output logic               timeout
);

    state_t               state;
    frame_t               cmd;
    logic [2:0]           rd_cnt;
    logic                 hs;
    logic                 tmr_expire;
    logic [FRAME_W-1:0]   rsp_frame;

    assign cmd  = frame_t'(frame);
    assign hs   = tx_valid && tx_ready;
    assign busy = (state != IDLE);

    always_comb begin
        rsp_frame                      = '0;
        rsp_frame[DATA_W-1:0]          = rd_data;
        rsp_frame[FRAME_W-1 -: 3]      = RSP_READ;
    end

    // Timer is held clear outside SEND so every response starts a fresh window.
    dbg_tx_timer #(
        .LIMIT (TX_TIMEOUT),
        .CNT_W (10)
    ) u_tx_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state != SEND),
        .en     ((state == SEND) && !hs),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            debug    <= 1'b0;
            reg_addr <= '0;
            rd_en    <= 1'b0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            tx_valid <= 1'b0;
            tx_frame <= '0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
            rd_cnt   <= '0;
        end else begin
            rd_en <= 1'b0;
            wr_en <= 1'b0;
            if (frame_valid && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        case (cmd.op)
                            OP_DEBUG_ON:  debug    <= 1'b1;
                            OP_DEBUG_OFF: debug    <= 1'b0;
                            OP_SELECT:    reg_addr <= cmd.payload[ADDR_W-1:0];
                            OP_READ: begin
                                rd_en  <= 1'b1;
                                rd_cnt <= '0;
                                state  <= RD_WAIT;
                            end
                            OP_WRITE: begin
                                wr_en   <= 1'b1;
                                wr_data <= cmd.payload[DATA_W-1:0];
                            end
                            OP_CLR_FLAGS: begin
                                overrun <= 1'b0;
                                timeout <= 1'b0;
                            end
                            OP_RSVD: begin
                                tx_frame <= NAK_FRAME;
                                tx_valid <= 1'b1;
                                state    <= SEND;
                            end
                            default: ;
                        endcase
                    end
                end
                RD_WAIT: begin
                    // rd_cnt is 0 in the rd_en cycle, so data is taken READ_LAT cycles later.
                    if (rd_cnt == 3'(READ_LAT)) begin
                        tx_frame <= rsp_frame;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (hs) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end else if (tmr_expire) begin
                        tx_valid <= 1'b0;
                        timeout  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Directed bench: instance a (READ_LAT=2, TX_TIMEOUT=16) and b (READ_LAT=1, TX_TIMEOUT=4) share stimulus.
module tb_debug_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       frame_valid;
    logic [8:0] frame;
    logic [3:0] rd_data;
    logic       tx_ready;

    logic       a_debug, a_rd_en, a_wr_en, a_tx_valid, a_busy, a_overrun, a_timeout;
    logic [2:0] a_reg_addr;
    logic [3:0] a_wr_data;
    logic [8:0] a_tx_frame;
    logic       b_debug, b_rd_en, b_wr_en, b_tx_valid, b_busy, b_overrun, b_timeout;
    logic [2:0] b_reg_addr;
    logic [3:0] b_wr_data;
    logic [8:0] b_tx_frame;

    int n_tests = 0;
    int n_fail  = 0;

    debug_cmd_sequencer #(.ADDR_W(3), .DATA_W(4), .READ_LAT(2), .TX_TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame(frame),
        .rd_data(rd_data), .tx_ready(tx_ready), .debug(a_debug), .reg_addr(a_reg_addr),
        .rd_en(a_rd_en), .wr_en(a_wr_en), .wr_data(a_wr_data), .tx_valid(a_tx_valid),
        .tx_frame(a_tx_frame), .busy(a_busy), .overrun(a_overrun), .timeout(a_timeout)
    );

    debug_cmd_sequencer #(.ADDR_W(3), .DATA_W(4), .READ_LAT(1), .TX_TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame(frame),
        .rd_data(rd_data), .tx_ready(tx_ready), .debug(b_debug), .reg_addr(b_reg_addr),
        .rd_en(b_rd_en), .wr_en(b_wr_en), .wr_data(b_wr_data), .tx_valid(b_tx_valid),
        .tx_frame(b_tx_frame), .busy(b_busy), .overrun(b_overrun), .timeout(b_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] f);
        frame_valid = 1'b1;
        frame       = f;
        tick();
        frame_valid = 1'b0;
        frame       = '0;
    endtask

    logic       stable;
    logic       strobes;

    initial begin
        rst         = 1'b0;
        frame_valid = 1'b0;
        frame       = '0;
        rd_data     = '0;
        tx_ready    = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_a_outs", {a_debug, a_reg_addr, a_rd_en, a_wr_en, a_wr_data, a_tx_valid,
                             a_tx_frame, a_busy, a_overrun, a_timeout}, 32'h0);
        check("rst_b_outs", {b_debug, b_reg_addr, b_rd_en, b_wr_en, b_wr_data, b_tx_valid,
                             b_tx_frame, b_busy, b_overrun, b_timeout}, 32'h0);
        rst = 1'b1;
        tick();

        // Async reset in the middle of SEND
        send(9'b111_000000);
        check("send_a_valid", a_tx_valid, 1);
        check("send_a_busy", a_busy, 1);
        tick();
        #2 rst = 1'b0;
        #1;
        check("arst_tx_valid", a_tx_valid, 0);
        check("arst_busy", a_busy, 0);
        check("arst_tx_frame", a_tx_frame, 0);
        tick();
        rst = 1'b1;
        tick();

        // Debug enable level
        send(9'b001_000000);
        check("debug_on", a_debug, 1);
        send(9'b010_000000);
        check("debug_off", a_debug, 0);

        // Select then write
        send(9'b011_000101);
        check("sel_addr", a_reg_addr, 5);
        check("sel_no_wr", a_wr_en, 0);
        send(9'b101_001010);
        check("wr_en", a_wr_en, 1);
        check("wr_data", a_wr_data, 4'hA);
        check("wr_addr", a_reg_addr, 5);
        check("wr_no_rd_tx", {a_rd_en, a_tx_valid}, 0);
        tick();
        check("wr_pulse_end", a_wr_en, 0);
        check("wr_no_tx", a_tx_valid, 0);

        // Read with READ_LAT=2; rd_data only valid in the sampling cycle
        tx_ready = 1'b1;
        send(9'b100_000000);
        check("rd_en_c1", a_rd_en, 1);
        check("rd_no_wr_c1", a_wr_en, 0);
        check("rd_busy_c1", a_busy, 1);
        tick();
        check("rd_en_c2", a_rd_en, 0);
        tick();
        rd_data = 4'h9;
        check("rd_tx_c3", a_tx_valid, 0);
        tick();
        rd_data = 4'h0;
        check("rd_tx_c4", a_tx_valid, 1);
        check("rd_frame_c4", a_tx_frame, 9'b100_001001);
        check("rd_busy_c4", a_busy, 1);
        tick();
        check("rd_busy_c5", a_busy, 0);
        check("rd_tx_c5", a_tx_valid, 0);

        // Backpressure with an overrun frame
        tx_ready = 1'b0;
        rd_data  = 4'h9;
        send(9'b100_000000);
        tick();
        tick();
        tick();
        check("bp_valid", a_tx_valid, 1);
        check("bp_frame", a_tx_frame, 9'b100_001001);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) send(9'b001_000000);
            else tick();
            if (!(a_tx_valid === 1'b1 && a_tx_frame === 9'b100_001001)) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_debug", a_debug, 0);
        check("bp_overrun", a_overrun, 1);
        tx_ready = 1'b1;
        tick();
        check("bp_hs_valid", a_tx_valid, 0);
        check("bp_hs_busy", a_busy, 0);
        tx_ready = 1'b0;
        rd_data  = 4'h0;

        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Reserved opcode and TX timeout on instance b
        strobes = 1'b0;
        send(9'b111_010101);
        strobes |= a_rd_en | a_wr_en | b_rd_en | b_wr_en;
        check("nak_a_frame", a_tx_frame, 9'b111_000000);
        check("nak_b_frame", b_tx_frame, 9'b111_000000);
        check("to_valid_1", b_tx_valid, 1);
        send(9'b001_000000);
        strobes |= a_rd_en | a_wr_en | b_rd_en | b_wr_en;
        tick();
        strobes |= a_rd_en | a_wr_en | b_rd_en | b_wr_en;
        tick();
        strobes |= a_rd_en | a_wr_en | b_rd_en | b_wr_en;
        check("to_valid_4", b_tx_valid, 1);
        tick();
        strobes |= a_rd_en | a_wr_en | b_rd_en | b_wr_en;
        check("to_valid_5", b_tx_valid, 0);
        check("to_flag", b_timeout, 1);
        check("to_idle", b_busy, 0);
        check("to_overrun", b_overrun, 1);
        check("to_debug", b_debug, 0);
        check("to_a_waiting", a_tx_valid, 1);
        check("nak_no_strobes", strobes, 0);

        send(9'b110_000000);
        check("clr_timeout", b_timeout, 0);
        check("clr_overrun", b_overrun, 0);
        check("clr_dropped_busy", a_overrun, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
